// File: rtl/frac_row_feeder_if.sv
// ---------------------------------------------------------------------------
// frac_row_feeder_if
//
// Purpose:
//   Bundles every non-clock signal between the block-fetch byte stream,
//   the row feeder and frac_search into one interface.
//
// Signals:
//   byte_in     [7:0]  serial pixel byte from the block-fetch stream
//   byte_valid         byte_in is valid this cycle
//   byte_ready         feeder accepts a byte this cycle
//   filter_pix  [63:0] filter row, pixel i in bits [8i+7:8i]
//   ref_pix     [63:0] reference row, same packing as filter_pix
//   input_ready        one-cycle strobe: a new row is on filter_pix/ref_pix
//   mvx, mvy    [2:0]  fractional motion vector from frac_search
//   mv_x_out    [2:0]  captured mvx
//   mv_y_out    [2:0]  captured mvy
//   mv_valid           one-cycle strobe: mv_x_out/mv_y_out were updated
//
// Modports:
//   slave  - the feeder's view (consumes bytes/MV, drives rows/MV results)
//   master - the surrounding environment's view
// ---------------------------------------------------------------------------
interface frac_row_feeder_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] filter_pix;
  logic [63:0] ref_pix;
  logic        input_ready;
  logic [2:0]  mvx;
  logic [2:0]  mvy;
  logic [2:0]  mv_x_out;
  logic [2:0]  mv_y_out;
  logic        mv_valid;

  modport slave (
    input  byte_in, byte_valid, mvx, mvy,
    output byte_ready, filter_pix, ref_pix, input_ready,
           mv_x_out, mv_y_out, mv_valid
  );

  modport master (
    output byte_in, byte_valid, mvx, mvy,
    input  byte_ready, filter_pix, ref_pix, input_ready,
           mv_x_out, mv_y_out, mv_valid
  );
endinterface

// File: rtl/frac_row_feeder.sv
// ---------------------------------------------------------------------------
// frac_row_feeder
//
// Purpose:
//   Producer side of the fractional-search row interface. Assembles a serial
//   byte stream into 64-bit filter and reference rows (16 bytes per row:
//   bytes 0..7 are filter pixels 0..7, bytes 8..15 are reference pixels
//   0..7) and presents each completed row to frac_search with a one-cycle
//   input_ready strobe. After the last row of a block it waits MV_LATENCY
//   cycles for frac_search to settle, then captures mvx/mvy into registered
//   outputs with a one-cycle mv_valid.
//
// Parameters:
//   ROWS        rows per block, 1..255
//   MV_LATENCY  cycles from the last row's input_ready to MV capture, 1..255
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; 0 clears all state immediately
//   bus    frac_row_feeder_if.slave (byte stream in, rows out, MV in/out)
// ---------------------------------------------------------------------------
module frac_row_feeder #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned MV_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  frac_row_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WAIT_MV = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(MV_LATENCY - 1);

  state_t      state_q,       state_d;
  logic [3:0]  byte_idx_q,    byte_idx_d;
  logic [7:0]  row_idx_q,     row_idx_d;
  logic [7:0]  wait_cnt_q,    wait_cnt_d;
  logic [63:0] filter_sh_q,   filter_sh_d;
  logic [63:0] ref_sh_q,      ref_sh_d;
  logic [63:0] filter_pix_q,  filter_pix_d;
  logic [63:0] ref_pix_q,     ref_pix_d;
  logic        input_ready_q, input_ready_d;
  logic        byte_ready_q,  byte_ready_d;
  logic [2:0]  mv_x_q,        mv_x_d;
  logic [2:0]  mv_y_q,        mv_y_d;
  logic        mv_valid_q,    mv_valid_d;

  logic        xfer;
  logic        last_byte;
  logic [5:0]  lane_lsb;

  // byte_ready is registered from the next state so that it is already 0
  // while in reset and only rises on the first edge after release; it then
  // always equals "state is IDLE or FILL".
  assign xfer      = bus.byte_valid && byte_ready_q;
  assign last_byte = xfer && (byte_idx_q == 4'd15);
  assign lane_lsb  = {byte_idx_q[2:0], 3'b000};

  // Next-state logic: byte assembly into the shadow rows, row issue,
  // block sequencing and motion-vector capture.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    row_idx_d     = row_idx_q;
    wait_cnt_d    = wait_cnt_q;
    filter_sh_d   = filter_sh_q;
    ref_sh_d      = ref_sh_q;
    filter_pix_d  = filter_pix_q;
    ref_pix_d     = ref_pix_q;
    input_ready_d = 1'b0;
    mv_x_d        = mv_x_q;
    mv_y_d        = mv_y_q;
    mv_valid_d    = 1'b0;

    // Low half of byte_idx selects the pixel lane, bit 3 selects filter/ref.
    if (xfer) begin
      if (!byte_idx_q[3]) begin
        filter_sh_d[lane_lsb +: 8] = bus.byte_in;
      end else begin
        ref_sh_d[lane_lsb +: 8] = bus.byte_in;
      end
      byte_idx_d = byte_idx_q + 4'd1;
    end

    // Issue uses the shadow value including the byte landing this cycle, so
    // the shadow can start refilling immediately with no bubble.
    if (last_byte) begin
      filter_pix_d  = filter_sh_d;
      ref_pix_d     = ref_sh_d;
      input_ready_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (last_byte) begin
          if (row_idx_q == LAST_ROW) begin
            row_idx_d  = 8'd0;
            wait_cnt_d = WAIT_LOAD;
            state_d    = WAIT_MV;
          end else begin
            row_idx_d = row_idx_q + 8'd1;
          end
        end
      end
      WAIT_MV: begin
        if (wait_cnt_q == 8'd0) begin
          state_d = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      CAPTURE: begin
        mv_x_d     = bus.mvx;
        mv_y_d     = bus.mvy;
        mv_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    byte_ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  // State register; asynchronous active-low reset discards any partial row
  // or pending wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      byte_idx_q    <= 4'd0;
      row_idx_q     <= 8'd0;
      wait_cnt_q    <= 8'd0;
      filter_sh_q   <= 64'd0;
      ref_sh_q      <= 64'd0;
      filter_pix_q  <= 64'd0;
      ref_pix_q     <= 64'd0;
      input_ready_q <= 1'b0;
      byte_ready_q  <= 1'b0;
      mv_x_q        <= 3'd0;
      mv_y_q        <= 3'd0;
      mv_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      row_idx_q     <= row_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      filter_sh_q   <= filter_sh_d;
      ref_sh_q      <= ref_sh_d;
      filter_pix_q  <= filter_pix_d;
      ref_pix_q     <= ref_pix_d;
      input_ready_q <= input_ready_d;
      byte_ready_q  <= byte_ready_d;
      mv_x_q        <= mv_x_d;
      mv_y_q        <= mv_y_d;
      mv_valid_q    <= mv_valid_d;
    end
  end

  assign bus.byte_ready  = byte_ready_q;
  assign bus.filter_pix  = filter_pix_q;
  assign bus.ref_pix     = ref_pix_q;
  assign bus.input_ready = input_ready_q;
  assign bus.mv_x_out    = mv_x_q;
  assign bus.mv_y_out    = mv_y_q;
  assign bus.mv_valid    = mv_valid_q;

endmodule

// File: tb/tb_frac_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_frac_row_feeder
//
// Drives byte rows into frac_row_feeder and checks every issued row and
// every captured motion vector against expectations queued when the
// stimulus is generated.
// ---------------------------------------------------------------------------
module tb_frac_row_feeder;

  localparam int ROWS       = 8;
  localparam int MV_LATENCY = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  frac_row_feeder_if bus ();

  frac_row_feeder #(
    .ROWS       (ROWS),
    .MV_LATENCY (MV_LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] f;
    logic [63:0] r;
  } row_t;

  int          compared   = 0;
  int          mismatched = 0;
  row_t        row_q[$];
  logic [5:0]  mv_q[$];
  longint      ir_cycles[$];
  longint      cyc        = 0;
  longint      last_ir    = 0;
  int          ir_total   = 0;
  int          mv_total   = 0;

  // Every comparison goes through here so the counters stay in one place.
  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle counter used to time input_ready spacing and MV latency.
  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard whenever the DUT strobes a row or
  // a motion vector, sampling on the falling edge.
  always @(negedge clk) begin
    row_t       e;
    logic [5:0] m;
    if (bus.input_ready === 1'b1) begin
      ir_total++;
      ir_cycles.push_back(cyc);
      last_ir = cyc;
      if (row_q.size() == 0) begin
        check_output("input_ready_expected", 64'(row_q.size() != 0), 64'd1);
      end else begin
        e = row_q.pop_front();
        check_output("filter_pix", bus.filter_pix, e.f);
        check_output("ref_pix", bus.ref_pix, e.r);
      end
    end
    if (bus.mv_valid === 1'b1) begin
      mv_total++;
      check_output("mv_latency", 64'(cyc - last_ir), 64'(MV_LATENCY + 1));
      if (mv_q.size() == 0) begin
        check_output("mv_valid_expected", 64'(mv_q.size() != 0), 64'd1);
      end else begin
        m = mv_q.pop_front();
        check_output("mv_x_out", 64'(bus.mv_x_out), 64'(m[5:3]));
        check_output("mv_y_out", 64'(bus.mv_y_out), 64'(m[2:0]));
      end
    end
  end

  // Offers one byte and holds it until the DUT accepts it; returns the
  // number of clock edges spent, including the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int waited);
    bit got;
    got            = 1'b0;
    waited         = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    do begin
      @(negedge clk);
      got = bus.byte_ready;
      @(posedge clk);
      waited++;
    end while (!got && waited < 100);
    #1;
    if (!got) check_output("byte_accept_timeout", 64'(got), 64'd1);
  endtask

  // Sends bytes base..base+nbytes-1 as one row; a complete row is queued on
  // the scoreboard. Optional random gaps plus a long gap after byte 7.
  task automatic apply_stimulus(input logic [7:0] base, input int nbytes,
                                input bit gaps, output int first_wait);
    row_t e;
    int   w;
    int   n;
    first_wait = 0;
    for (int i = 0; i < 8; i++) begin
      e.f[8*i +: 8] = 8'(base + 8'(i));
      e.r[8*i +: 8] = 8'(base + 8'(i + 8));
    end
    if (nbytes == 16) row_q.push_back(e);
    for (int i = 0; i < nbytes; i++) begin
      n = 0;
      if (gaps && i > 0) n = int'($urandom_range(0, 3)) + ((i == 8) ? 20 : 0);
      if (n > 0) begin
        bus.byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
      end
      send_byte(8'(base + 8'(i)), w);
      if (i == 0) first_wait = w;
    end
    bus.byte_valid = 1'b0;
  endtask

  // Directed sequence: reset, single row, stalled block, back-to-back block
  // with backpressure, reset mid-row, recovery row.
  initial begin
    int w;
    bus.byte_in    = 8'h55;
    bus.byte_valid = 1'b1;
    bus.mvx        = 3'd0;
    bus.mvy        = 3'd0;
    #1 reset = 1'b0;

    // Reset state with byte_valid held high.
    repeat (3) @(negedge clk);
    check_output("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check_output("rst_input_ready", 64'(bus.input_ready), 64'd0);
    check_output("rst_mv_valid", 64'(bus.mv_valid), 64'd0);
    check_output("rst_filter_pix", bus.filter_pix, 64'd0);
    check_output("rst_ref_pix", bus.ref_pix, 64'd0);
    check_output("rst_mv_x_out", 64'(bus.mv_x_out), 64'd0);
    check_output("rst_mv_y_out", 64'(bus.mv_y_out), 64'd0);

    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    check_output("idle_byte_ready", 64'(bus.byte_ready), 64'd1);

    // Single row 00..0F.
    $display("[TB] single-row packing");
    bus.mvx = 3'd3;
    bus.mvy = 3'd6;
    apply_stimulus(8'h00, 16, 1'b0, w);
    @(negedge clk);
    check_output("row0_filter", bus.filter_pix, 64'h0706050403020100);
    check_output("row0_ref", bus.ref_pix, 64'h0F0E0D0C0B0A0908);
    @(posedge clk);
    #1;
    check_output("row0_pulses", 64'(ir_total), 64'd1);

    // Remaining rows of block 1 with random gaps.
    $display("[TB] stalled rows");
    for (int r = 1; r < ROWS; r++) begin
      if (r == ROWS - 1) mv_q.push_back({3'd3, 3'd6});
      apply_stimulus(8'(8'h10 * r), 16, 1'b1, w);
    end
    repeat (10) @(posedge clk);
    #1;
    check_output("block1_pulses", 64'(ir_total), 64'(ROWS));
    check_output("block1_mv_count", 64'(mv_total), 64'd1);

    // Back-to-back block, then a held byte during WAIT_MV/CAPTURE.
    $display("[TB] full block with backpressure");
    bus.mvx = 3'd5;
    bus.mvy = 3'd2;
    ir_cycles.delete();
    for (int r = 0; r < ROWS; r++) begin
      if (r == ROWS - 1) mv_q.push_back({3'd5, 3'd2});
      apply_stimulus(8'(8'h80 + 8'h10 * (r % 8)), 16, 1'b0, w);
    end
    apply_stimulus(8'h40, 16, 1'b0, w);
    check_output("backpressure_wait", 64'(w), 64'(MV_LATENCY + 2));
    check_output("block2_pulse_count", 64'(ir_cycles.size()), 64'(ROWS));
    for (int i = 0; i + 1 < ir_cycles.size(); i++) begin
      check_output("row_spacing", 64'(ir_cycles[i+1] - ir_cycles[i]), 64'd16);
    end
    bus.mvx = 3'd1;
    bus.mvy = 3'd7;

    // Rows 1..2 of block 3, then 11 bytes of row 3 and an async reset.
    $display("[TB] reset mid-row");
    apply_stimulus(8'h50, 16, 1'b0, w);
    apply_stimulus(8'h60, 16, 1'b0, w);
    apply_stimulus(8'h70, 11, 1'b0, w);
    #3 reset = 1'b0;
    #1;
    check_output("midrst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check_output("midrst_input_ready", 64'(bus.input_ready), 64'd0);
    check_output("midrst_filter_pix", bus.filter_pix, 64'd0);
    check_output("midrst_ref_pix", bus.ref_pix, 64'd0);
    check_output("midrst_mv_x_out", 64'(bus.mv_x_out), 64'd0);
    check_output("midrst_mv_y_out", 64'(bus.mv_y_out), 64'd0);
    check_output("midrst_mv_valid", 64'(bus.mv_valid), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fresh row after reset starts at byte 0 of row 0.
    apply_stimulus(8'hAA, 16, 1'b0, w);
    @(negedge clk);
    check_output("post_rst_filter", bus.filter_pix, 64'hB1B0AFAEADACABAA);
    check_output("post_rst_ref", bus.ref_pix, 64'hB9B8B7B6B5B4B3B2);

    repeat (30) @(posedge clk);
    #1;
    check_output("total_row_pulses", 64'(ir_total), 64'd20);
    check_output("total_mv_pulses", 64'(mv_total), 64'd2);
    check_output("rows_left_queued", 64'(row_q.size()), 64'd0);
    check_output("mvs_left_queued", 64'(mv_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
